shake_serial_tx: RTL

Host-side transmitter for the SHAKE256 2-bit serial input protocol. Accepts a byte stream on a valid/ready interface and drives the core's start, enable, serial_in and serial_end_signal with the exact framing the core expects. It then waits for the core's done and reports completion. It sits between the message source (host FIFO or bus bridge) and the SHAKE256 top.

---
 rtl/shake_pkg.sv | 22 ++
 rtl/shake_serial_tx_if.sv | 44 ++++
 rtl/shake_byte_serializer.sv | 45 ++++
 rtl/shake_serial_tx.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/shake_pkg.sv
// Shared SHAKE256 constants and the serial transmitter state encoding.
package shake_pkg;

  localparam int unsigned STATE_WIDTH     = 1600;
  localparam int unsigned RATE_WIDTH      = 1088;
  localparam int unsigned OUT_BITS        = 256;
  localparam int unsigned RATE_BYTES      = 136;
  localparam int unsigned CHUNKS_PER_BYTE = 4;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_SGAP,
    S_WAIT_BYTE,
    S_SEND,
    S_BGAP,
    S_EGAP,
    S_END,
    S_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/shake_serial_tx_if.sv
// Host byte stream and SHAKE256 core serial-input signals for shake_serial_tx.
// SHAKE_TX_TIMEOUT_EN adds the sticky timeout flag.
interface shake_serial_tx_if #(
  parameter int unsigned CNT_W = 11
) ();

  logic             msg_start;
  logic             msg_empty;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_last;
  logic             byte_ready;
  logic             core_start;
  logic             core_enable;
  logic [1:0]       core_serial_in;
  logic             core_serial_end;
  logic             core_done;
  logic             busy;
  logic             msg_done;
  logic [CNT_W-1:0] byte_count;
  logic             overflow;
`ifdef SHAKE_TX_TIMEOUT_EN
  logic             timeout;
`endif

  modport master (
    input  msg_start, msg_empty, byte_in, byte_valid, byte_last, core_done,
    output byte_ready, core_start, core_enable, core_serial_in, core_serial_end,
    output busy, msg_done, byte_count, overflow
`ifdef SHAKE_TX_TIMEOUT_EN
    , output timeout
`endif
  );

  modport slave (
    output msg_start, msg_empty, byte_in, byte_valid, byte_last, core_done,
    input  byte_ready, core_start, core_enable, core_serial_in, core_serial_end,
    input  busy, msg_done, byte_count, overflow
`ifdef SHAKE_TX_TIMEOUT_EN
    , input timeout
`endif
  );

endinterface

// File: rtl/shake_byte_serializer.sv
// Splits a loaded byte into MSB-first 2-bit chunks; the chunk output is registered
// and returns to 0 once the last chunk has been consumed.
module shake_byte_serializer
  import shake_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_byte,
  input  logic       i_advance,
  output logic [1:0] o_chunk,
  output logic       o_chunk_done_c
);

  localparam int unsigned IDX_W = 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS_PER_BYTE - 1);

  logic [7:0]       r_shift;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_chunk;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_idx   <= '0;
      r_chunk <= '0;
    end else if (i_load) begin
      r_chunk <= i_byte[7:6];
      r_shift <= {i_byte[5:0], 2'b00};
      r_idx   <= '0;
    end else if (i_advance) begin
      if (r_idx == LAST_IDX) begin
        r_chunk <= '0;
      end else begin
        r_chunk <= r_shift[7:6];
        r_shift <= {r_shift[5:0], 2'b00};
        r_idx   <= IDX_W'(r_idx + 1'b1);
      end
    end
  end

  assign o_chunk        = r_chunk;
  assign o_chunk_done_c = (r_idx == LAST_IDX);

endmodule

// File: rtl/shake_serial_tx.sv
// Host-side framer for the SHAKE256 2-bit serial input: start, gaps, chunks, serial_end, done.
// Optional SHAKE_TX_TIMEOUT_EN bounds the wait for core done.
module shake_serial_tx
  import shake_pkg::*;
#(
  parameter int unsigned START_GAP = 2,
  parameter int unsigned BYTE_GAP  = 1,
  parameter int unsigned MAX_BYTES = RATE_BYTES,
  parameter int unsigned CNT_W     = 11
`ifdef SHAKE_TX_TIMEOUT_EN
  , parameter int unsigned DONE_TIMEOUT = 4096
`endif
) (
  input  logic              clk,
  input  logic              reset,
  shake_serial_tx_if.master bus
);

  localparam int unsigned GAP_W = 16;

  tx_state_e        r_state, w_next;
  logic [GAP_W-1:0] r_gap;
  logic             r_empty, r_last;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow, r_byte_ready, r_core_start, r_core_enable;
  logic             r_core_end, r_busy, r_msg_done;
  logic             w_hs, w_full, w_load, w_advance, w_chunk_done, w_done_seen, w_tmo;
  logic [1:0]       w_chunk;

  assign w_hs        = bus.byte_valid & r_byte_ready;
  assign w_full      = (r_count >= CNT_W'(MAX_BYTES));
  // A done level still held from the previous message is only honoured from the second cycle
  assign w_done_seen = (r_gap != '0) && bus.core_done;

`ifdef SHAKE_TX_TIMEOUT_EN
  logic r_timeout;
  assign w_tmo       = (r_gap >= GAP_W'(DONE_TIMEOUT - 1));
  assign bus.timeout = r_timeout;
`else
  assign w_tmo = 1'b0;
`endif

  shake_byte_serializer u_ser (
    .clk            (clk),
    .reset          (reset),
    .i_load         (w_load),
    .i_byte         (bus.byte_in),
    .i_advance      (w_advance),
    .o_chunk        (w_chunk),
    .o_chunk_done_c (w_chunk_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      S_IDLE:      if (bus.msg_start) w_next = S_START;
      S_START:     if (START_GAP == 0) w_next = r_empty ? S_EGAP : S_WAIT_BYTE;
                   else                w_next = S_SGAP;
      S_SGAP:      if (r_gap == GAP_W'(START_GAP - 1)) w_next = r_empty ? S_EGAP : S_WAIT_BYTE;
      S_WAIT_BYTE: begin
        // Bytes past the rate limit are accepted and dropped so the source never stalls
        if (w_hs) begin
          if (w_full) begin
            if (bus.byte_last) w_next = S_EGAP;
          end else begin
            w_load = 1'b1;
            w_next = S_SEND;
          end
        end
      end
      S_SEND: begin
        w_advance = 1'b1;
        if (w_chunk_done) begin
          if (BYTE_GAP == 0) w_next = r_last ? S_EGAP : S_WAIT_BYTE;
          else               w_next = S_BGAP;
        end
      end
      S_BGAP:      if (r_gap == GAP_W'(BYTE_GAP - 1)) w_next = r_last ? S_EGAP : S_WAIT_BYTE;
      S_EGAP:      w_next = S_END;
      S_END:       w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (w_done_seen || w_tmo) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs are registered decodes of the next state so they line up with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gap         <= '0;
      r_empty       <= 1'b0;
      r_last        <= 1'b0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_byte_ready  <= 1'b0;
      r_core_start  <= 1'b0;
      r_core_enable <= 1'b0;
      r_core_end    <= 1'b0;
      r_busy        <= 1'b0;
      r_msg_done    <= 1'b0;
`ifdef SHAKE_TX_TIMEOUT_EN
      r_timeout     <= 1'b0;
`endif
    end else begin
      if (w_next != r_state) r_gap <= '0;
      else if (r_gap != '1)  r_gap <= GAP_W'(r_gap + 1'b1);

      if (r_state == S_IDLE && bus.msg_start) begin
        r_empty    <= bus.msg_empty;
        r_count    <= '0;
        r_overflow <= 1'b0;
`ifdef SHAKE_TX_TIMEOUT_EN
        r_timeout  <= 1'b0;
`endif
      end
      if (w_load) begin
        r_last  <= bus.byte_last;
        r_count <= CNT_W'(r_count + 1'b1);
      end
      if (r_state == S_WAIT_BYTE && w_hs && w_full) r_overflow <= 1'b1;
`ifdef SHAKE_TX_TIMEOUT_EN
      if (r_state == S_WAIT_DONE && !w_done_seen && w_tmo) r_timeout <= 1'b1;
`endif

      r_byte_ready  <= (w_next == S_WAIT_BYTE);
      r_core_start  <= (w_next == S_START);
      r_core_enable <= (w_next == S_SEND);
      r_core_end    <= (w_next == S_END);
      r_busy        <= (w_next != S_IDLE);
      r_msg_done    <= (r_state == S_WAIT_DONE) && (w_next == S_IDLE);
    end
  end

  assign bus.byte_ready      = r_byte_ready;
  assign bus.core_start      = r_core_start;
  assign bus.core_enable     = r_core_enable;
  assign bus.core_serial_in  = w_chunk;
  assign bus.core_serial_end = r_core_end;
  assign bus.busy            = r_busy;
  assign bus.msg_done        = r_msg_done;
  assign bus.byte_count      = r_count;
  assign bus.overflow        = r_overflow;

endmodule
